// File: rtl/player_motion_if.sv
// Button/collision inputs and position outputs between the motion controller and the maze renderer.
// master = motion controller, slave = renderer/board side.
interface player_motion_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       collision;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] mapa_pos_x;
  logic [2:0] mapa_pos_y;
  logic       busy;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, collision,
    output x_pos, y_pos, mapa_pos_x, mapa_pos_y, busy
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, collision,
    input  x_pos, y_pos, mapa_pos_x, mapa_pos_y, busy
  );
endinterface

// File: rtl/player_motion.sv
// Steps the cube once per movement tick in the button direction, crossing rooms at the edges,
// and rolls the whole step back if the renderer reports a wall collision COLL_LAT cycles later.
module player_motion #(
  parameter int STEP_DIV    = 416667,
  parameter int STEP        = 2,
  parameter int COLL_LAT    = 2,
  parameter int X_MIN       = 96,
  parameter int X_MAX       = 720,
  parameter int Y_MIN       = 2,
  parameter int Y_MAX       = 466,
  parameter int X_START     = 408,
  parameter int Y_START     = 234,
  parameter int MAP_W       = 3,
  parameter int MAP_H       = 3,
  parameter int MAP_START_X = 1,
  parameter int MAP_START_Y = 1
) (
  input  logic CLOCK_25,
  input  logic reset,
  player_motion_if.master pm
);

  localparam int TW = $clog2(STEP_DIV);
  localparam int WW = (COLL_LAT < 2) ? 1 : $clog2(COLL_LAT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(COLL_LAT);
  localparam logic [10:0]   STEP_W    = 11'(STEP);
  localparam logic [10:0]   XMIN_W    = 11'(X_MIN);
  localparam logic [10:0]   XMAX_W    = 11'(X_MAX);
  localparam logic [10:0]   YMIN_W    = 11'(Y_MIN);
  localparam logic [10:0]   YMAX_W    = 11'(Y_MAX);
  localparam logic [2:0]    MX_LAST   = 3'(MAP_W - 1);
  localparam logic [2:0]    MY_LAST   = 3'(MAP_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK} state_t;

  state_t         state_q, state_d;
  logic [3:0]     btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, dir_q, dir_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic           tick_pend_q, tick_pend_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [9:0]     x_q, x_d, y_q, y_d, sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [2:0]     mx_q, mx_d, my_q, my_d, sh_mx_q, sh_mx_d, sh_my_q, sh_my_d;
  logic [10:0]    x_w, y_w;
  logic           tick_wrap, tick_take;

  always_comb begin
    btn_s1_d   = {pm.btn_up, pm.btn_down, pm.btn_left, pm.btn_right};
    btn_s2_d   = btn_s1_q;
    tick_wrap  = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    tick_take  = 1'b0;
    state_d    = state_q;
    wait_d     = wait_q;
    dir_d      = dir_q;
    x_d        = x_q;
    y_d        = y_q;
    mx_d       = mx_q;
    my_d       = my_q;
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_mx_d    = sh_mx_q;
    sh_my_d    = sh_my_q;
    x_w        = {1'b0, x_q};
    y_w        = {1'b0, y_q};

    case (state_q)
      S_IDLE: begin
        if (tick_pend_q) begin
          tick_take = 1'b1;
          if (|btn_s2_q) begin
            // Direction is frozen here so later button changes cannot alter this step.
            dir_d   = btn_s2_q;
            sh_x_d  = x_q;
            sh_y_d  = y_q;
            sh_mx_d = mx_q;
            sh_my_d = my_q;
            state_d = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        state_d = S_WAIT;
        wait_d  = WAIT_LOAD;
        if (dir_q[3]) begin
          if (y_w >= YMIN_W + STEP_W) y_d = 10'(y_w - STEP_W);
          else if (my_q != 3'd0) begin
            my_d = my_q - 3'd1;
            y_d  = 10'(Y_MAX);
          end else y_d = 10'(Y_MIN);
        end else if (dir_q[2]) begin
          if (y_w + STEP_W <= YMAX_W) y_d = 10'(y_w + STEP_W);
          else if (my_q < MY_LAST) begin
            my_d = my_q + 3'd1;
            y_d  = 10'(Y_MIN);
          end else y_d = 10'(Y_MAX);
        end else if (dir_q[1]) begin
          if (x_w >= XMIN_W + STEP_W) x_d = 10'(x_w - STEP_W);
          else if (mx_q != 3'd0) begin
            mx_d = mx_q - 3'd1;
            x_d  = 10'(X_MAX);
          end else x_d = 10'(X_MIN);
        end else begin
          if (x_w + STEP_W <= XMAX_W) x_d = 10'(x_w + STEP_W);
          else if (mx_q < MX_LAST) begin
            mx_d = mx_q + 3'd1;
            x_d  = 10'(X_MIN);
          end else x_d = 10'(X_MAX);
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= WW'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (pm.collision) begin
          x_d  = sh_x_q;
          y_d  = sh_y_q;
          mx_d = sh_mx_q;
          my_d = sh_my_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A wrap while a tick is still pending collapses into that one tick.
    tick_pend_d = (tick_pend_q & ~tick_take) | tick_wrap;
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q     <= S_IDLE;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      dir_q       <= '0;
      tick_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
      wait_q      <= '0;
      x_q         <= 10'(X_START);
      y_q         <= 10'(Y_START);
      mx_q        <= 3'(MAP_START_X);
      my_q        <= 3'(MAP_START_Y);
      sh_x_q      <= 10'(X_START);
      sh_y_q      <= 10'(Y_START);
      sh_mx_q     <= 3'(MAP_START_X);
      sh_my_q     <= 3'(MAP_START_Y);
    end else begin
      state_q     <= state_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      dir_q       <= dir_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_pend_q <= tick_pend_d;
      wait_q      <= wait_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_mx_q     <= sh_mx_d;
      sh_my_q     <= sh_my_d;
    end
  end

  assign pm.x_pos      = x_q;
  assign pm.y_pos      = y_q;
  assign pm.mapa_pos_x = mx_q;
  assign pm.mapa_pos_y = my_q;
  assign pm.busy       = (state_q != S_IDLE);

endmodule
